// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Elastic chain of STAGES pipeline slots that carries a packed WIDTH-bit bundle
//   with valid/ready flow control. Each slot has a main register and, when SKID=1,
//   a second skid register, so in_ready comes straight from a flop. With SKID=0
//   in_ready is combinational from out_ready through every slot.
//   flush_mask[i] empties slot i at the next edge. A bundle moving into the slot
//   on that edge is discarded. A bundle leaving the slot on that edge is still
//   delivered.
//   Empty slots hold BUBBLE, and out_data shows BUBBLE while out_valid is low.
//
// Ports
//   clk         rising-edge clock
//   nrst        asynchronous active-low reset
//   in_valid    upstream bundle valid
//   in_ready    chain accepts in_data this cycle (forced low during reset)
//   in_data     upstream bundle
//   out_valid   last slot holds a valid bundle
//   out_ready   downstream accepts out_data this cycle
//   out_data    last-slot bundle, BUBBLE when out_valid=0
//   flush_mask  bit i squashes slot i (bit 0 = input side) at the next edge
//   occupancy   registered count of valid entries (main + skid) in the chain
module pipe_stage_chain #(
   parameter int               WIDTH  = 32,
   parameter int               STAGES = 1,
   parameter bit               SKID   = 1'b1,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [WIDTH-1:0]                   in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [WIDTH-1:0]                   out_data,
   input  logic [STAGES-1:0]                  flush_mask,
   output logic [$clog2(2*STAGES+1)-1:0]      occupancy
);

   localparam int OCC_W = $clog2(2*STAGES+1);

   logic [STAGES-1:0] up_rdy;
   logic [STAGES-1:0] dn_rdy;
   logic [STAGES-1:0] slot_v;
   logic [STAGES-1:0] main_v_nxt;
   logic [STAGES-1:0] skid_v_nxt;
   logic [WIDTH-1:0]  slot_d [STAGES];
   logic [OCC_W-1:0]  occ_d;
   logic [OCC_W-1:0]  occ_q;

   for (genvar i = 0; i < STAGES; i++) begin : g_slot
      logic             feed_v;
      logic [WIDTH-1:0] feed_d;
      logic             take;
      logic             drain;
      logic             vm_q;
      logic             vm_d;
      logic [WIDTH-1:0] dm_q;
      logic [WIDTH-1:0] dm_d;

      if (i == 0) begin : g_head
         assign feed_v = in_valid;
         assign feed_d = in_data;
      end else begin : g_body
         assign feed_v = slot_v[i-1];
         assign feed_d = slot_d[i-1];
      end

      if (i == STAGES-1) begin : g_tail
         assign dn_rdy[i] = out_ready;
      end else begin : g_mid
         assign dn_rdy[i] = up_rdy[i+1];
      end

      assign take  = feed_v & up_rdy[i];
      assign drain = vm_q & dn_rdy[i];

      if (SKID) begin : g_skid
         logic             vs_q;
         logic             vs_d;
         logic [WIDTH-1:0] ds_q;
         logic [WIDTH-1:0] ds_d;

         // Readiness depends only on the skid flop, which cuts the ready path.
         assign up_rdy[i] = ~vs_q;

         // take implies the skid is empty, so the skid->main move never
         // collides with an incoming bundle.
         always_comb begin
            vm_d = vm_q;
            dm_d = dm_q;
            vs_d = vs_q;
            ds_d = ds_q;
            if (flush_mask[i]) begin
               vm_d = 1'b0;
               dm_d = BUBBLE;
               vs_d = 1'b0;
               ds_d = BUBBLE;
            end else if (vs_q && drain) begin
               vm_d = 1'b1;
               dm_d = ds_q;
               vs_d = 1'b0;
               ds_d = BUBBLE;
            end else if (take && (!vm_q || drain)) begin
               vm_d = 1'b1;
               dm_d = feed_d;
            end else if (take) begin
               vs_d = 1'b1;
               ds_d = feed_d;
            end else if (drain) begin
               vm_d = 1'b0;
               dm_d = BUBBLE;
            end
         end

         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               vs_q <= 1'b0;
               ds_q <= BUBBLE;
            end else begin
               vs_q <= vs_d;
               ds_q <= ds_d;
            end
         end

         assign skid_v_nxt[i] = vs_d;
      end else begin : g_noskid
         // Combinational ready chain: a full slot is ready when it drains this edge.
         assign up_rdy[i] = ~vm_q | dn_rdy[i];

         always_comb begin
            vm_d = vm_q;
            dm_d = dm_q;
            if (flush_mask[i]) begin
               vm_d = 1'b0;
               dm_d = BUBBLE;
            end else if (take) begin
               vm_d = 1'b1;
               dm_d = feed_d;
            end else if (drain) begin
               vm_d = 1'b0;
               dm_d = BUBBLE;
            end
         end

         assign skid_v_nxt[i] = 1'b0;
      end

      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            vm_q <= 1'b0;
            dm_q <= BUBBLE;
         end else begin
            vm_q <= vm_d;
            dm_q <= dm_d;
         end
      end

      assign slot_v[i]     = vm_q;
      assign slot_d[i]     = dm_q;
      assign main_v_nxt[i] = vm_d;
   end

   // Count from next-state valids so occupancy lines up with the slot contents.
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_d = occ_d + OCC_W'(main_v_nxt[i]) + OCC_W'(skid_v_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) occ_q <= '0;
      else       occ_q <= occ_d;
   end

   assign in_ready  = up_rdy[0] & nrst;
   assign out_valid = slot_v[STAGES-1];
   assign out_data  = slot_v[STAGES-1] ? slot_d[STAGES-1] : BUBBLE;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;
   localparam int W = 16;
   localparam logic [W-1:0] BUB = 16'hB0B0;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   // dut a: STAGES=3, SKID=1 ; dut b: STAGES=2, SKID=0
   logic a_iv = 0, a_ir, a_ov, a_or = 0;
   logic [W-1:0] a_id = '0, a_od;
   logic [2:0] a_fl = '0, a_occ;
   logic b_iv = 0, b_ir, b_ov, b_or = 0;
   logic [W-1:0] b_id = '0, b_od;
   logic [1:0] b_fl = '0;
   logic [2:0] b_occ;

   pipe_stage_chain #(.WIDTH(W), .STAGES(3), .SKID(1'b1), .BUBBLE(BUB)) u_a (
      .clk(clk), .nrst(nrst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
      .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .flush_mask(a_fl),
      .occupancy(a_occ));

   pipe_stage_chain #(.WIDTH(W), .STAGES(2), .SKID(1'b0), .BUBBLE(BUB)) u_b (
      .clk(clk), .nrst(nrst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .flush_mask(b_fl),
      .occupancy(b_occ));

   // Reference: each slot is a small FIFO (depth 2 with skid, depth 1 without).
   // Queues 0..2 belong to chain a, 3..4 to chain b.
   logic [W-1:0] mq [5][$];
   logic [W-1:0] obs_a [$];
   logic [W-1:0] obs_b [$];
   int n_chk = 0, n_bad = 0;
   int cyc = 0;
   int acc_first, del_first, ovcnt_a, acc_cnt_a;
   logic last_acc_a = 0, last_acc_b = 0;
   logic seen_aa = 0, aa_acc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int base(input int c);
      return (c == 0) ? 0 : 3;
   endfunction

   function automatic int nst(input int c);
      return (c == 0) ? 3 : 2;
   endfunction

   function automatic logic [3:0] m_ready(input int c, input logic oready);
      logic [3:0] r;
      logic down;
      r = '0;
      for (int i = nst(c) - 1; i >= 0; i--) begin
         down = (i == nst(c) - 1) ? oready : r[i+1];
         if (c == 0) r[i] = (mq[base(c)+i].size() < 2);
         else        r[i] = (mq[base(c)+i].size() == 0) || down;
      end
      return r;
   endfunction

   task automatic m_step(input int c, input logic iv, input logic [W-1:0] id,
                         input logic oready, input logic [2:0] fl, output logic acc);
      logic [3:0] r;
      logic [W-1:0] t;
      int b, s;
      b = base(c);
      s = nst(c);
      r = m_ready(c, oready);
      if (mq[b+s-1].size() > 0 && oready) t = mq[b+s-1].pop_front();
      for (int i = s - 1; i >= 1; i--)
         if (mq[b+i-1].size() > 0 && r[i]) mq[b+i].push_back(mq[b+i-1].pop_front());
      acc = iv && r[0];
      if (acc) mq[b].push_back(id);
      for (int i = 0; i < s; i++)
         if (fl[i]) mq[b+i].delete();
   endtask

   task automatic check_all();
      logic [3:0] r;
      r = m_ready(0, a_or);
      chk("a_out_valid", a_ov, mq[2].size() > 0);
      chk("a_out_data", a_od, (mq[2].size() > 0) ? mq[2][0] : BUB);
      chk("a_occupancy", a_occ, mq[0].size() + mq[1].size() + mq[2].size());
      chk("a_in_ready", a_ir, nrst ? r[0] : 1'b0);
      r = m_ready(1, b_or);
      chk("b_out_valid", b_ov, mq[4].size() > 0);
      chk("b_out_data", b_od, (mq[4].size() > 0) ? mq[4][0] : BUB);
      chk("b_occupancy", b_occ, mq[3].size() + mq[4].size());
      chk("b_in_ready", b_ir, nrst ? r[0] : 1'b0);
   endtask

   task automatic cycle();
      logic acc_a, acc_b;
      @(negedge clk);
      check_all();
      if (a_ov && a_or) obs_a.push_back(a_od);
      if (b_ov && b_or) obs_b.push_back(b_od);
      if (a_ov && a_od == 16'h00AA) seen_aa = 1'b1;
      if (a_iv && a_ir && a_id == 16'h00AA) aa_acc = 1'b1;
      if (a_iv && a_ir) acc_cnt_a++;
      if (a_ov) ovcnt_a++;
      if (a_iv && a_ir && acc_first < 0) acc_first = cyc;
      if (a_ov && a_or && del_first < 0) del_first = cyc;
      @(posedge clk);
      if (nrst) begin
         m_step(0, a_iv, a_id, a_or, a_fl, acc_a);
         m_step(1, b_iv, b_id, b_or, {1'b0, b_fl}, acc_b);
      end else begin
         for (int i = 0; i < 5; i++) mq[i].delete();
         acc_a = 1'b0;
         acc_b = 1'b0;
      end
      last_acc_a = acc_a;
      last_acc_b = acc_b;
      cyc++;
      #1;
   endtask

   initial begin
      int idx;
      logic pulsed;
      logic [W-1:0] p5 [3];

      // reset state, before any clock edge
      #2;
      chk("rst_a_ov", a_ov, 1'b0);
      chk("rst_a_od", a_od, BUB);
      chk("rst_a_occ", a_occ, 3'd0);
      chk("rst_a_ir", a_ir, 1'b0);
      chk("rst_b_ir", b_ir, 1'b0);
      cycle();
      cycle();
      nrst = 1'b1;

      // back-to-back 0x11..0x18, out_ready=1
      a_or = 1'b1; b_or = 1'b1;
      obs_a.delete(); acc_first = -1; del_first = -1; ovcnt_a = 0; idx = 0;
      for (int k = 0; k < 14; k++) begin
         a_iv = (idx < 8);
         a_id = 16'h11 + 16'(idx);
         cycle();
         if (last_acc_a) idx++;
      end
      a_iv = 1'b0;
      chk("p2_count", obs_a.size(), 8);
      for (int i = 0; i < 8; i++) chk("p2_order", obs_a[i], 16'h11 + i);
      chk("p2_latency", del_first - acc_first, 3);
      chk("p2_valid_cycles", ovcnt_a, 8);

      // stall for 10 cycles while pushing
      a_or = 1'b0; acc_cnt_a = 0; idx = 0; obs_a.delete();
      for (int k = 0; k < 10; k++) begin
         a_iv = 1'b1;
         a_id = 16'h31 + 16'(idx);
         cycle();
         if (last_acc_a) idx++;
      end
      chk("p3_accepted", acc_cnt_a, 6);
      chk("p3_occupancy", a_occ, 3'd6);
      chk("p3_in_ready", a_ir, 1'b0);
      a_or = 1'b1;
      for (int k = 0; k < 12; k++) begin
         a_iv = (idx < 7);
         a_id = 16'h31 + 16'(idx);
         cycle();
         if (last_acc_a) idx++;
      end
      a_iv = 1'b0;
      chk("p3_count", obs_a.size(), 7);
      for (int i = 0; i < 7; i++) chk("p3_order", obs_a[i], 16'h31 + i);

      // flush slot 1 while streaming 0x21..0x26
      for (int k = 0; k < 3; k++) cycle();
      chk("p4_empty", a_occ, 3'd0);
      obs_a.delete(); idx = 0; pulsed = 1'b0;
      for (int k = 0; k < 12; k++) begin
         a_iv = (idx < 6);
         a_id = 16'h21 + 16'(idx);
         a_fl = (idx == 2 && !pulsed) ? 3'b010 : 3'b000;
         if (a_fl != 3'b000) pulsed = 1'b1;
         cycle();
         if (last_acc_a) idx++;
      end
      a_iv = 1'b0; a_fl = '0;
      chk("p4_count", obs_a.size(), 5);
      chk("p4_w0", obs_a[0], 16'h21);
      for (int i = 1; i < 5; i++) chk("p4_order", obs_a[i], 16'h22 + i);

      // flush slot 0 in the cycle 0xAA is accepted
      p5[0] = 16'h41; p5[1] = 16'hAA; p5[2] = 16'h42;
      obs_a.delete(); idx = 0; seen_aa = 1'b0; aa_acc = 1'b0;
      for (int k = 0; k < 8; k++) begin
         a_iv = (idx < 3);
         a_id = (idx < 3) ? p5[idx] : 16'h0;
         a_fl = (idx == 1) ? 3'b001 : 3'b000;
         cycle();
         if (last_acc_a) idx++;
      end
      a_iv = 1'b0; a_fl = '0;
      chk("p5_aa_accepted", aa_acc, 1'b1);
      chk("p5_aa_seen", seen_aa, 1'b0);
      chk("p5_count", obs_a.size(), 2);
      chk("p5_w0", obs_a[0], 16'h41);
      chk("p5_w1", obs_a[1], 16'h42);

      // async reset with 4 entries held
      a_or = 1'b0; idx = 0;
      for (int k = 0; k < 4; k++) begin
         a_iv = 1'b1;
         a_id = 16'h51 + 16'(idx);
         cycle();
         if (last_acc_a) idx++;
      end
      chk("p6_occ_before", a_occ, 3'd4);
      #2;
      nrst = 1'b0;
      a_iv = 1'b0;
      for (int i = 0; i < 5; i++) mq[i].delete();
      #1;
      chk("p6_ov", a_ov, 1'b0);
      chk("p6_od", a_od, BUB);
      chk("p6_occ", a_occ, 3'd0);
      chk("p6_ir", a_ir, 1'b0);
      cycle();
      cycle();
      nrst = 1'b1;
      a_or = 1'b1;

      // chain b, combinational ready
      b_or = 1'b0; idx = 0; obs_b.delete();
      for (int k = 0; k < 4; k++) begin
         b_iv = 1'b1;
         b_id = 16'h61 + 16'(idx);
         cycle();
         if (last_acc_b) idx++;
      end
      chk("p7_full", b_occ, 3'd2);
      chk("p7_ir_stall", b_ir, 1'b0);
      b_or = 1'b1;
      #1;
      chk("p7_ir_release", b_ir, 1'b1);
      for (int k = 0; k < 8; k++) begin
         b_iv = (idx < 8);
         b_id = 16'h61 + 16'(idx);
         cycle();
         if (last_acc_b) idx++;
      end
      b_iv = 1'b0;
      chk("p7_throughput", obs_b.size(), 8);
      for (int i = 0; i < 8; i++) chk("p7_order", obs_b[i], 16'h61 + i);

      // randomized traffic on both chains
      for (int k = 0; k < 600; k++) begin
         if (!a_iv || last_acc_a) begin
            a_iv = ($urandom_range(0, 3) != 0);
            a_id = 16'($urandom_range(0, 16'h0FFF));
         end
         if (!b_iv || last_acc_b) begin
            b_iv = ($urandom_range(0, 3) != 0);
            b_id = 16'($urandom_range(0, 16'h0FFF));
         end
         a_or = ($urandom_range(0, 3) != 0);
         b_or = ($urandom_range(0, 3) != 0);
         a_fl = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         b_fl = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
